// File: rtl/branch_resolve_if.sv
// Redirect handshake between branch_resolve (master) and the PC mux (slave).
//   Redirect_valid : master -> slave, a taken-branch target is being presented
//   Redirect_pc    : master -> slave, the target address, stable while valid
//   Redirect_ack   : slave -> master, target accepted
interface branch_resolve_if #(
  parameter int DATA_W = 16
);
  logic              Redirect_valid;
  logic [DATA_W-1:0] Redirect_pc;
  logic              Redirect_ack;

  modport master (output Redirect_valid, output Redirect_pc, input Redirect_ack);
  modport slave  (input Redirect_valid, input Redirect_pc, output Redirect_ack);
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: forms BEN from the latched NZP flags and the IR n/z/p mask,
// and for a taken BR presents PC+SEXT(IR[OFF_W-1:0]) to the PC mux.
// Ports:
//   Clk, Reset (async, active low)
//   LD_BEN        evaluate strobe from the control FSM (accepted in IDLE only)
//   IR, PC, NZP   instruction, incremented PC, condition codes {N,Z,P}
//   rdr           redirect handshake (master side): valid / pc / ack
//   BEN           registered branch-enable, held until the next accepted LD_BEN
//   Busy          FSM is not in IDLE
//   Done          one-cycle pulse when an evaluation retires
// Optional macro BRANCH_STATS_EN adds saturating Taken_cnt / NotTaken_cnt,
// counting branch-opcode evaluations only.
module branch_resolve #(
  parameter int          DATA_W    = 16,
  parameter int          OFF_W     = 9,
  parameter logic [3:0]  BR_OPCODE = 4'b0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LD_BEN,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] PC,
  input  logic [2:0]        NZP,
  branch_resolve_if.master  rdr,
  output logic              BEN,
  output logic              Busy,
  output logic              Done
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       Taken_cnt,
  output logic [15:0]       NotTaken_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] tgt;
  logic [DATA_W-1:0] off_sx;
  logic              is_br;
  logic              load, take, retire_nt, retire_ack;

  assign off_sx = {{(DATA_W-OFF_W){IR[OFF_W-1]}}, IR[OFF_W-1:0]};
  assign Busy   = (state != IDLE);

  always_comb begin
    state_d    = state;
    load       = 1'b0;
    take       = 1'b0;
    retire_nt  = 1'b0;
    retire_ack = 1'b0;
    case (state)
      IDLE:
        if (LD_BEN) begin
          load    = 1'b1;
          state_d = EVAL;
        end
      EVAL:
        if (BEN && is_br) begin
          take    = 1'b1;
          state_d = REDIRECT;
        end else begin
          retire_nt = 1'b1;
          state_d   = IDLE;
        end
      // Ack is only sampled here, so an ack seen during EVAL or IDLE is dropped.
      REDIRECT:
        if (rdr.Redirect_ack) begin
          retire_ack = 1'b1;
          state_d    = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state              <= IDLE;
      BEN                <= 1'b0;
      tgt                <= '0;
      is_br              <= 1'b0;
      rdr.Redirect_valid <= 1'b0;
      rdr.Redirect_pc    <= '0;
      Done               <= 1'b0;
    end else begin
      state <= state_d;
      Done  <= retire_nt | retire_ack;
      if (load) begin
        BEN   <= |(IR[11:9] & NZP);
        tgt   <= PC + off_sx;  // modulo 2^DATA_W
        is_br <= (IR[15:12] == BR_OPCODE);
      end
      if (take) begin
        rdr.Redirect_valid <= 1'b1;
        rdr.Redirect_pc    <= tgt;
      end else if (retire_ack) begin
        rdr.Redirect_valid <= 1'b0;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Taken_cnt    <= '0;
      NotTaken_cnt <= '0;
    end else begin
      if (take && Taken_cnt != 16'hFFFF)
        Taken_cnt <= Taken_cnt + 16'd1;
      if (retire_nt && is_br && NotTaken_cnt != 16'hFFFF)
        NotTaken_cnt <= NotTaken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        LD_BEN;
  logic [15:0] IR, PC;
  logic [2:0]  NZP;
  logic        BEN, Busy, Done;
`ifdef BRANCH_STATS_EN
  logic [15:0] Taken_cnt, NotTaken_cnt;
`endif

  branch_resolve_if #(.DATA_W(16)) rdr ();

  branch_resolve #(.DATA_W(16), .OFF_W(9), .BR_OPCODE(4'b0000)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .LD_BEN (LD_BEN),
    .IR     (IR),
    .PC     (PC),
    .NZP    (NZP),
    .rdr    (rdr),
    .BEN    (BEN),
    .Busy   (Busy),
    .Done   (Done)
`ifdef BRANCH_STATS_EN
    ,
    .Taken_cnt    (Taken_cnt),
    .NotTaken_cnt (NotTaken_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        ben;
    logic        taken;
    logic [15:0] pc;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] last_rpc = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: retire one scoreboard entry per Done pulse.
  logic        seen_rv = 1'b0;
  logic [15:0] rv_pc   = 16'h0;
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      seen_rv = 1'b0;
    end else begin
      if (rdr.Redirect_valid) begin
        if (!seen_rv) begin
          seen_rv = 1'b1;
          rv_pc   = rdr.Redirect_pc;
        end else begin
          chk("mon_rpc_stable", rdr.Redirect_pc, rv_pc);
        end
      end
      if (Done) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL mon_unexpected_done actual=1 required=0 at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("mon_ben", BEN, e.ben);
          chk("mon_taken", seen_rv, e.taken);
          if (e.taken) chk("mon_pc", rv_pc, e.pc);
        end
        seen_rv = 1'b0;
      end
    end
  end

  // Called at posedge+1 with the FSM in IDLE.
  task automatic run_br(input logic [15:0] ir, input logic [15:0] pc, input logic [2:0] nzp,
                        input logic eben, input logic etaken, input logic [15:0] epc,
                        input int hold, input bit ack_early, input bit poke);
    exp_t e;
    e.ben = eben; e.taken = etaken; e.pc = epc;
    sbq.push_back(e);
    IR = ir; PC = pc; NZP = nzp; LD_BEN = 1'b1;
    @(posedge Clk); #1;
    LD_BEN = 1'b0;
    chk("ben_lat1", BEN, eben);
    chk("busy_eval", Busy, 1);
    chk("rv_eval", rdr.Redirect_valid, 0);
    if (ack_early) rdr.Redirect_ack = 1'b1;
    @(posedge Clk); #1;
    rdr.Redirect_ack = 1'b0;
    if (etaken) begin
      chk("rv_lat2", rdr.Redirect_valid, 1);
      chk("rpc_lat2", rdr.Redirect_pc, epc);
      chk("done_redir", Done, 0);
      for (int i = 0; i < hold; i++) begin
        if (poke) begin IR = 16'h0000; NZP = 3'b111; LD_BEN = 1'b1; end
        @(posedge Clk); #1;
        LD_BEN = 1'b0;
        chk("rv_hold", rdr.Redirect_valid, 1);
        chk("rpc_hold", rdr.Redirect_pc, epc);
        chk("ben_hold", BEN, eben);
        chk("busy_hold", Busy, 1);
      end
      rdr.Redirect_ack = 1'b1;
      @(posedge Clk); #1;
      rdr.Redirect_ack = 1'b0;
      chk("rv_after_ack", rdr.Redirect_valid, 0);
      last_rpc = epc;
    end else begin
      chk("rv_nt", rdr.Redirect_valid, 0);
      chk("rpc_unchanged", rdr.Redirect_pc, last_rpc);
    end
    chk("done_pulse", Done, 1);
    chk("busy_idle", Busy, 0);
    @(posedge Clk); #1;
    chk("done_one_cycle", Done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; LD_BEN = 1'b0; IR = '0; PC = '0; NZP = '0;
    rdr.Redirect_ack = 1'b0;
    #2;
    chk("rst_ben", BEN, 0);
    chk("rst_rv", rdr.Redirect_valid, 0);
    chk("rst_rpc", rdr.Redirect_pc, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;

    // BRz +5, Z set: taken to 0x3006
    run_br(16'h0405, 16'h3001, 3'b010, 1'b1, 1'b1, 16'h3006, 0, 1'b0, 1'b0);
    // BRn, P set: not taken, Redirect_pc keeps 0x3006
    run_br(16'h0805, 16'h3001, 3'b001, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
    // BRnzp -256 from 0x0010 wraps to 0xFF10; ack during EVAL must be ignored
    run_br(16'h0F00, 16'h0010, 3'b100, 1'b1, 1'b1, 16'hFF10, 1, 1'b1, 1'b0);
    // BRnzp +1 from 0xFFFF wraps to 0x0000; LD_BEN pulsed while waiting 5 cycles
    run_br(16'h0E01, 16'hFFFF, 3'b001, 1'b1, 1'b1, 16'h0000, 5, 1'b0, 1'b1);
`ifdef BRANCH_STATS_EN
    chk("stat_taken_a", Taken_cnt, 3);
    chk("stat_nt_a", NotTaken_cnt, 1);
`endif
    // ADD with mask bits 111: BEN=1 but no redirect, not counted
    run_br(16'h1E3F, 16'h3001, 3'b001, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("stat_taken_add", Taken_cnt, 3);
    chk("stat_nt_add", NotTaken_cnt, 1);
`endif
    // NZP never loaded: BEN=0 even with mask 111
    run_br(16'h0E00, 16'h1234, 3'b000, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
    // Mask 000 is a NOP
    run_br(16'h0000, 16'h1234, 3'b111, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("stat_taken_b", Taken_cnt, 3);
    chk("stat_nt_b", NotTaken_cnt, 3);
`endif

    // Reset asserted while in REDIRECT
    IR = 16'h0405; PC = 16'h3001; NZP = 3'b010; LD_BEN = 1'b1;
    @(posedge Clk); #1;
    LD_BEN = 1'b0;
    @(posedge Clk); #1;
    chk("mid_rv_set", rdr.Redirect_valid, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_rv", rdr.Redirect_valid, 0);
    chk("async_ben", BEN, 0);
    chk("async_busy", Busy, 0);
    chk("async_rpc", rdr.Redirect_pc, 0);
`ifdef BRANCH_STATS_EN
    chk("async_taken", Taken_cnt, 0);
    chk("async_nt", NotTaken_cnt, 0);
`endif
    @(posedge Clk); #1;
    Reset = 1'b1;
    last_rpc = 16'h0000;
    @(posedge Clk); #1;
    chk("post_rst_busy", Busy, 0);
    chk("post_rst_rv", rdr.Redirect_valid, 0);
    run_br(16'h0405, 16'h3001, 3'b010, 1'b1, 1'b1, 16'h3006, 2, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("stat_taken_c", Taken_cnt, 1);
`endif

    repeat (4) @(posedge Clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
